// File: rtl/line_buffer_ctrl.sv
// Line-buffer controller: steers pixel writes around a ring of line SRAMs,
// tracks fill level and frame position, and appends internal flush rows so
// the window datapath can emit the bottom border without extra input.
//
// Handshake: a pixel is accepted on a rising edge where clken=1 and
// in_ready=1 (in_ready is low only while flushing); there is no back-pressure
// on the output side, and out_valid is a one-cycle qualifier for out_col/out_row.
module line_buffer_ctrl #(
    parameter int NUM_LINE   = 5,
    parameter int AWIDTH     = 11,
    parameter int HWIDTH     = 11,
    parameter int FLUSH_ROWS = 2,
    localparam int PW        = (NUM_LINE > 1) ? $clog2(NUM_LINE) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clken,
    input  logic                sof,
    input  logic [AWIDTH-1:0]   width,
    input  logic [HWIDTH-1:0]   height,
    output logic                in_ready,
    output logic [NUM_LINE-1:0] wr_en,
    output logic [AWIDTH-1:0]   wr_addr,
    output logic [AWIDTH-1:0]   rd_addr,
    output logic [PW-1:0]       head_ptr,
    output logic [NUM_LINE-1:0] valid,
    output logic                out_valid,
    output logic [AWIDTH-1:0]   out_col,
    output logic [HWIDTH-1:0]   out_row,
    output logic                frame_done,
    output logic [1:0]          fsm_state
);

    localparam int FILL_DEPTH = NUM_LINE - 1 - FLUSH_ROWS;
    localparam int FCW        = $clog2(NUM_LINE) + 1;
    localparam logic [HWIDTH-1:0] FILL_ROWS  = HWIDTH'(FILL_DEPTH);
    localparam logic [FCW-1:0]    FLUSH_LAST = FCW'((FLUSH_ROWS > 0) ? FLUSH_ROWS - 1 : 0);
    localparam logic [PW-1:0]     HEAD_MAX   = PW'(NUM_LINE - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t              state, state_n;
    logic [AWIDTH-1:0]   col, width_r;
    logic [HWIDTH-1:0]   rows_done, height_r;
    logic [PW-1:0]       head;
    logic [FCW-1:0]      flush_cnt;
    logic                done_pend;

    logic                start, pix, fl_stb, stb, wrap, last_pix, last_flush, emit;
    logic [AWIDTH-1:0]   cur_col, cur_w;
    logic [HWIDTH-1:0]   cur_rows, cur_h, rows_inc;
    logic [PW-1:0]       cur_head, head_inc;
    logic [NUM_LINE-1:0] line_sel, valid_base;

    assign head_ptr  = head;
    assign fsm_state = state;

    // Strobe decode, current-position selection (sof restarts at 0,0) and next state.
    always_comb begin
        start      = clken && sof && (state != FLUSH);
        pix        = clken && !sof && ((state == FILL) || (state == RUN));
        fl_stb     = (state == FLUSH);
        stb        = start || pix || fl_stb;
        cur_col    = start ? '0 : col;
        cur_rows   = start ? '0 : rows_done;
        cur_head   = start ? '0 : head;
        cur_w      = start ? width : width_r;
        cur_h      = start ? height : height_r;
        valid_base = start ? '0 : valid;
        line_sel   = NUM_LINE'(1) << cur_head;
        wrap       = stb && (cur_col == cur_w - AWIDTH'(1));
        rows_inc   = (cur_rows == '1) ? cur_rows : cur_rows + HWIDTH'(1);
        head_inc   = (cur_head == HEAD_MAX) ? '0 : cur_head + PW'(1);
        last_pix   = (start || pix) && wrap && (cur_rows == cur_h - HWIDTH'(1));
        last_flush = fl_stb && wrap && (flush_cnt == FLUSH_LAST);
        emit       = stb && (cur_rows >= FILL_ROWS);
        state_n    = state;
        if (start || pix) begin
            if (last_pix)
                state_n = (FLUSH_ROWS > 0) ? FLUSH : IDLE;
            else if ((wrap ? rows_inc : cur_rows) >= FILL_ROWS)
                state_n = RUN;
            else
                state_n = FILL;
        end else if (last_flush) begin
            state_n = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // Position counters, ring pointer, fill tracking and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col        <= '0;
            width_r    <= '0;
            rows_done  <= '0;
            height_r   <= '0;
            head       <= '0;
            flush_cnt  <= '0;
            done_pend  <= 1'b0;
            valid      <= '0;
            wr_en      <= '1;
            wr_addr    <= '0;
            rd_addr    <= '0;
            out_valid  <= 1'b0;
            out_col    <= '0;
            out_row    <= '0;
            frame_done <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            in_ready   <= (state_n != FLUSH);
            frame_done <= done_pend;
            done_pend  <= (last_pix && (FLUSH_ROWS == 0)) || last_flush;
            wr_en      <= '1;
            out_valid  <= 1'b0;
            if (start) begin
                width_r  <= width;
                height_r <= height;
            end
            if (start || last_pix)
                flush_cnt <= '0;
            else if (fl_stb && wrap)
                flush_cnt <= flush_cnt + FCW'(1);
            if (stb) begin
                col     <= wrap ? '0 : cur_col + AWIDTH'(1);
                wr_addr <= cur_col;
                rd_addr <= cur_col;
                if (wrap) begin
                    head      <= head_inc;
                    rows_done <= rows_inc;
                    valid     <= valid_base | line_sel;
                end else begin
                    head      <= cur_head;
                    rows_done <= cur_rows;
                    valid     <= valid_base;
                end
                if (start || pix)
                    wr_en <= ~line_sel;
                if (emit) begin
                    out_valid <= 1'b1;
                    out_col   <= cur_col;
                    out_row   <= cur_rows - FILL_ROWS;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl: randomized frames, a reference model that
// enumerates the expected per-pixel and per-flush-column events of a frame,
// and a negedge monitor that pops and compares every DUT event.
module tb_line_buffer_ctrl;

    localparam int NL = 5;
    localparam int AW = 11;
    localparam int HW = 11;
    localparam int FR = 2;
    localparam int D  = NL - 1 - FR;
    localparam int PW = $clog2(NL);

    typedef struct packed {
        logic [NL-1:0] wr_en;
        logic [AW-1:0] addr;
        logic [AW-1:0] rd;
        logic          ov;
        logic [AW-1:0] col;
        logic [HW-1:0] row;
        logic [PW-1:0] head;
        logic [NL-1:0] valid;
        logic          rdy;
        logic          fin;
    } ev_t;
    localparam int EW = $bits(ev_t);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clken = 1'b0;
    logic          sof = 1'b0;
    logic [AW-1:0] width = '0;
    logic [HW-1:0] height = '0;
    logic          in_ready;
    logic [NL-1:0] wr_en;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [PW-1:0] head_ptr;
    logic [NL-1:0] valid;
    logic          out_valid;
    logic [AW-1:0] out_col;
    logic [HW-1:0] out_row;
    logic          frame_done;
    logic [1:0]    fsm_state;

    logic [EW-1:0] exp_q[$];
    int  n_cmp = 0;
    int  n_fail = 0;
    bit  done_due = 1'b0;

    line_buffer_ctrl #(.NUM_LINE(NL), .AWIDTH(AW), .HWIDTH(HW), .FLUSH_ROWS(FR)) dut (
        .clk(clk), .rst(rst), .clken(clken), .sof(sof), .width(width), .height(height),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr(rd_addr),
        .head_ptr(head_ptr), .valid(valid), .out_valid(out_valid), .out_col(out_col),
        .out_row(out_row), .frame_done(frame_done), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // reference model: lines holding a completed row after 'done' rows
    function automatic logic [NL-1:0] valid_for(input int done);
        logic [NL-1:0] v = '0;
        for (int k = 0; k < done && k < NL; k++) v[k] = 1'b1;
        return v;
    endfunction

    // one expected event for image row rr (rows >= height are flush rows)
    task automatic push_ev(input int w, input int rr, input int c, input bit flush,
                           input bit fin, input bit rdy);
        ev_t e;
        int  done;
        done    = rr + ((c == w - 1) ? 1 : 0);
        e.wr_en = flush ? '1 : ~(NL'(1) << (rr % NL));
        e.addr  = AW'(c);
        e.rd    = AW'(c);
        e.ov    = (rr >= D);
        e.col   = AW'(c);
        e.row   = HW'(rr - D);
        e.head  = PW'(done % NL);
        e.valid = valid_for(done);
        e.rdy   = rdy;
        e.fin   = fin;
        exp_q.push_back(EW'(e));
    endtask

    // driver: one frame; ar/ac name the pixel at which a new sof interrupts it
    task automatic run_frame(input int w, input int h, input int gap,
                             input int ar, input int ac);
        bit last;
        width  = AW'(w);
        height = HW'(h);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (r == ar && c == ac) begin
                    clken = 1'b0;
                    sof   = 1'b0;
                    return;
                end
                while (gap > 0 && $urandom_range(0, 99) < gap) begin
                    clken = 1'b0;
                    sof   = 1'b0;
                    tick();
                end
                last  = (r == h - 1) && (c == w - 1);
                clken = 1'b1;
                sof   = (r == 0 && c == 0);
                push_ev(w, r, c, 1'b0, last && (FR == 0), last ? (FR == 0) : 1'b1);
                tick();
            end
        end
        clken = 1'b0;
        sof   = 1'b0;
        for (int fr = 0; fr < FR; fr++) begin
            for (int c = 0; c < w; c++) begin
                if (h + fr >= D)
                    push_ev(w, h + fr, c, 1'b1, (fr == FR - 1) && (c == w - 1),
                            (fr == FR - 1) && (c == w - 1));
            end
        end
    endtask

    task automatic wait_drain;
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d events still pending, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

    task automatic chk(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, expv);
        end
    endtask

    task automatic check_reset;
        chk("rst_wr_en", longint'(wr_en), longint'({NL{1'b1}}));
        chk("rst_wr_addr", longint'(wr_addr), 0);
        chk("rst_rd_addr", longint'(rd_addr), 0);
        chk("rst_head_ptr", longint'(head_ptr), 0);
        chk("rst_valid", longint'(valid), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_col", longint'(out_col), 0);
        chk("rst_out_row", longint'(out_row), 0);
        chk("rst_frame_done", longint'(frame_done), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
    endtask

    // scoreboard monitor: frame_done timing and every write/window event
    always @(negedge clk) begin
        if (rst) begin
            if (frame_done || done_due) begin
                n_cmp++;
                if (frame_done !== done_due) begin
                    n_fail++;
                    $display("FAIL frame_done: got %0b required %0b", frame_done, done_due);
                end
            end
            done_due = 1'b0;
            if (wr_en !== '1 || out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got wr_en=%b out_valid=%b required none",
                             wr_en, out_valid);
                end else begin
                    ev_t e, a;
                    e       = ev_t'(exp_q.pop_front());
                    a.wr_en = wr_en;
                    a.addr  = wr_addr;
                    a.rd    = rd_addr;
                    a.ov    = out_valid;
                    a.col   = e.ov ? out_col : e.col;
                    a.row   = e.ov ? out_row : e.row;
                    a.head  = head_ptr;
                    a.valid = valid;
                    a.rdy   = in_ready;
                    a.fin   = e.fin;
                    if (a !== e) begin
                        n_fail++;
                        $display("FAIL event: got wr_en=%b addr=%0d rd=%0d ov=%b col=%0d row=%0d head=%0d valid=%b rdy=%b required wr_en=%b addr=%0d rd=%0d ov=%b col=%0d row=%0d head=%0d valid=%b rdy=%b",
                                 a.wr_en, a.addr, a.rd, a.ov, a.col, a.row, a.head, a.valid, a.rdy,
                                 e.wr_en, e.addr, e.rd, e.ov, e.col, e.row, e.head, e.valid, e.rdy);
                    end
                    if (e.fin) done_due = 1'b1;
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        repeat (3) tick();
        check_reset();
        rst = 1'b1;
        tick();

        // continuous strobe, 8x6
        run_frame(8, 6, 0, -1, -1);
        wait_drain();
        // same frame with random gaps
        run_frame(8, 6, 35, -1, -1);
        wait_drain();
        // ring wrap: row 5 lands on line 0 again
        run_frame(5, 7, 20, -1, -1);
        wait_drain();
        // abort at row 3 col 4, new frame restarts immediately
        run_frame(8, 6, 10, 3, 4);
        run_frame(6, 5, 10, -1, -1);
        wait_drain();
        // random frame sizes, including single-row and single-column frames
        for (int i = 0; i < 6; i++) begin
            run_frame($urandom_range(1, 10), $urandom_range(1, 7), $urandom_range(0, 40), -1, -1);
            wait_drain();
        end
        // reset in the middle of the flush rows
        run_frame(8, 3, 0, -1, -1);
        repeat (4) tick();
        rst = 1'b0;
        tick();
        exp_q.delete();
        done_due = 1'b0;
        check_reset();
        rst = 1'b1;
        tick();
        run_frame(7, 4, 15, -1, -1);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
